trap_ctrl: RTL and testbench

Trap sequencer for the single-issue core. Watches the instruction in EX, recognises `ecall`, `unimp` and `mret`, and drives the CSR file's single write port through a fixed multi-cycle sequence: EPC, then cause, then status. It then redirects fetch and flushes younger instructions. It holds the current privilege level and stalls the pipeline while a sequence is in flight.

---
 rtl/trap_ctrl_if.sv | 25 ++
 rtl/trap_ctrl.sv | 86 ++++++++
 tb/tb_trap_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: EX-stage view, CSR write port and fetch redirect bundle for trap_ctrl
interface trap_ctrl_if;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [63:0] ex_pc;
  logic [63:0] mtvec_in;
  logic [63:0] mepc_in;
  logic [63:0] mstatus_in;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic        hold;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0]  priv;
  modport master (
    output ex_valid, ex_inst, ex_pc, mtvec_in, mepc_in, mstatus_in,
    input  csr_we, csr_addr, csr_wdata, hold, flush, redirect_valid, redirect_pc, priv
  );
  modport slave (
    input  ex_valid, ex_inst, ex_pc, mtvec_in, mepc_in, mstatus_in,
    output csr_we, csr_addr, csr_wdata, hold, flush, redirect_valid, redirect_pc, priv
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences ecall/unimp/mret through EPC, cause and status CSR writes, then redirects fetch
module trap_ctrl (
  input logic      clk,
  input logic      rst,
  trap_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STAT, R_STAT, REDIR} state_t;
  state_t      state_q, state_d;
  logic [63:0] mstat_q;
  logic [3:0]  cause_q;
  logic        ret_q;
  logic [1:0]  priv_q;
  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [63:0] csr_wdata_q, csr_wdata_d;
  logic        redir_q, redir_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic        is_ecall, is_unimp, is_mret, hit;
  logic [63:0] stat_trap, stat_ret;
  assign is_ecall = bus.ex_inst == 32'h0000_0073;
  assign is_unimp = bus.ex_inst == 32'hc000_1073;
  assign is_mret  = bus.ex_inst == 32'h3020_0073;
  assign hit      = bus.ex_valid && (is_ecall || is_unimp || is_mret) && state_q == IDLE;
  // Status images: trap stacks MIE into MPIE and records priv; return unstacks from the live value at detect
  assign stat_trap = {mstat_q[63:13], priv_q, mstat_q[10:8], mstat_q[3], mstat_q[6:4], 1'b0, mstat_q[2:0]};
  assign stat_ret  = {bus.mstatus_in[63:13], 2'b00, bus.mstatus_in[10:8], 1'b1,
                      bus.mstatus_in[6:4], bus.mstatus_in[7], bus.mstatus_in[2:0]};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = hit ? (is_mret ? R_STAT : W_EPC) : IDLE;
      W_EPC:   state_d = W_CAUSE;
      W_CAUSE: state_d = W_STAT;
      W_STAT:  state_d = REDIR;
      R_STAT:  state_d = REDIR;
      default: state_d = IDLE;
    endcase
    csr_we_d      = state_d inside {W_EPC, W_CAUSE, W_STAT, R_STAT};
    csr_addr_d    = state_d == W_EPC   ? 12'h341 :
                    state_d == W_CAUSE ? 12'h342 :
                    csr_we_d           ? 12'h300 : 12'h000;
    csr_wdata_d   = state_d == W_EPC   ? bus.ex_pc :
                    state_d == W_CAUSE ? {60'b0, cause_q} :
                    state_d == W_STAT  ? stat_trap :
                    state_d == R_STAT  ? stat_ret : 64'b0;
    redir_d       = state_d == REDIR;
    // Target is sampled on entry to REDIR so a just-retired mtvec/mepc write is seen
    redirect_pc_d = !redir_d ? 64'b0 : ret_q ? bus.mepc_in : bus.mtvec_in & ~64'h3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mstat_q       <= '0;
      cause_q       <= '0;
      ret_q         <= 1'b0;
      priv_q        <= 2'b11;
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      redir_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      csr_we_q      <= csr_we_d;
      csr_addr_q    <= csr_addr_d;
      csr_wdata_q   <= csr_wdata_d;
      redir_q       <= redir_d;
      redirect_pc_q <= redirect_pc_d;
      if (hit) begin
        mstat_q <= bus.mstatus_in;
        cause_q <= is_unimp ? 4'd2 : {2'b10, priv_q};
        ret_q   <= is_mret;
      end
      if (state_q == W_STAT) priv_q <= 2'b11;
      else if (state_q == R_STAT) priv_q <= mstat_q[12:11];
    end
  end
  assign bus.csr_we         = csr_we_q;
  assign bus.csr_addr       = csr_addr_q;
  assign bus.csr_wdata      = csr_wdata_q;
  assign bus.hold           = hit || state_q != IDLE;
  assign bus.flush          = redir_q;
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.priv           = priv_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vectors for trap_ctrl with hand-computed CSR writes, redirects and priv
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  trap_ctrl_if bus ();
  trap_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [31:0] ECALL = 32'h0000_0073, UNIMP = 32'hc000_1073, MRET = 32'h3020_0073;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input string tag, input logic [11:0] a, input logic [63:0] d);
    chk({tag, "_we"}, {63'b0, bus.csr_we}, 64'd1);
    chk({tag, "_addr"}, {52'b0, bus.csr_addr}, {52'b0, a});
    chk({tag, "_wdata"}, bus.csr_wdata, d);
  endtask
  task automatic redir(input string tag, input logic [63:0] pc);
    chk({tag, "_we"}, {63'b0, bus.csr_we}, 64'd0);
    chk({tag, "_rv"}, {63'b0, bus.redirect_valid}, 64'd1);
    chk({tag, "_flush"}, {63'b0, bus.flush}, 64'd1);
    chk({tag, "_rpc"}, bus.redirect_pc, pc);
    chk({tag, "_hold"}, {63'b0, bus.hold}, 64'd1);
  endtask
  task automatic idle(input string tag);
    chk({tag, "_rv"}, {63'b0, bus.redirect_valid}, 64'd0);
    chk({tag, "_flush"}, {63'b0, bus.flush}, 64'd0);
    chk({tag, "_we"}, {63'b0, bus.csr_we}, 64'd0);
    chk({tag, "_hold"}, {63'b0, bus.hold}, 64'd0);
  endtask
  task automatic issue(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] ms);
    bus.ex_valid = 1'b1;
    bus.ex_inst = inst;
    bus.ex_pc = pc;
    bus.mstatus_in = ms;
    #1;
    chk("detect_hold", {63'b0, bus.hold}, 64'd1);
    step();
    bus.ex_valid = 1'b0;
  endtask
  initial begin
    bus.ex_valid = 1'b0;
    bus.ex_inst = '0;
    bus.ex_pc = '0;
    bus.mtvec_in = 64'h8000_1003;
    bus.mepc_in = '0;
    bus.mstatus_in = '0;
    rst = 1'b1;
    repeat (2) step();
    chk("rst_we", {63'b0, bus.csr_we}, 64'd0);
    chk("rst_addr", {52'b0, bus.csr_addr}, 64'd0);
    chk("rst_wdata", bus.csr_wdata, 64'd0);
    chk("rst_flush", {63'b0, bus.flush}, 64'd0);
    chk("rst_rv", {63'b0, bus.redirect_valid}, 64'd0);
    chk("rst_rpc", bus.redirect_pc, 64'd0);
    chk("rst_priv", {62'b0, bus.priv}, 64'd3);
    chk("rst_hold", {63'b0, bus.hold}, 64'd0);
    rst = 1'b0;
    step();
    // matching word without ex_valid does nothing
    bus.ex_inst = ECALL;
    #1;
    chk("novalid_hold", {63'b0, bus.hold}, 64'd0);
    step();
    idle("novalid");
    // ECALL from M; mtvec changes after detect and the new value must be used
    issue(ECALL, 64'h8000_0010, 64'h0);
    bus.mtvec_in = 64'h8000_2001;
    wr("ec_epc", 12'h341, 64'h8000_0010);
    chk("ec_hold1", {63'b0, bus.hold}, 64'd1);
    step();
    wr("ec_cause", 12'h342, 64'd11);
    step();
    wr("ec_stat", 12'h300, 64'h1800);
    chk("ec_priv_t3", {62'b0, bus.priv}, 64'd3);
    step();
    redir("ec_redir", 64'h8000_2000);
    step();
    idle("ec_done");
    // UNIMP with MIE set
    issue(UNIMP, 64'h100, 64'h8);
    wr("un_epc", 12'h341, 64'h100);
    step();
    wr("un_cause", 12'h342, 64'd2);
    step();
    wr("un_stat", 12'h300, 64'h1880);
    step();
    redir("un_redir", 64'h8000_2000);
    step();
    idle("un_done");
    // MRET to U
    bus.mepc_in = 64'h2000;
    issue(MRET, 64'h500, 64'h80);
    wr("mr_stat", 12'h300, 64'h88);
    chk("mr_priv_t1", {62'b0, bus.priv}, 64'd3);
    step();
    redir("mr_redir", 64'h2000);
    chk("mr_priv_t2", {62'b0, bus.priv}, 64'd0);
    step();
    idle("mr_done");
    // ECALL from U: cause 8, MPP=0, zero-data status write still issued
    issue(ECALL, 64'h2004, 64'h0);
    wr("eu_epc", 12'h341, 64'h2004);
    step();
    wr("eu_cause", 12'h342, 64'd8);
    step();
    wr("eu_stat", 12'h300, 64'h0);
    chk("eu_priv_t3", {62'b0, bus.priv}, 64'd0);
    step();
    redir("eu_redir", 64'h8000_2000);
    chk("eu_priv_t4", {62'b0, bus.priv}, 64'd3);
    step();
    idle("eu_done");
    // second ECALL arriving during W_CAUSE is ignored
    issue(ECALL, 64'h3000, 64'h0);
    wr("ig_epc", 12'h341, 64'h3000);
    step();
    bus.ex_valid = 1'b1;
    bus.ex_pc = 64'h3004;
    #1;
    wr("ig_cause", 12'h342, 64'd11);
    chk("ig_hold2", {63'b0, bus.hold}, 64'd1);
    step();
    wr("ig_stat", 12'h300, 64'h1800);
    step();
    redir("ig_redir", 64'h8000_2000);
    bus.ex_valid = 1'b0;
    step();
    idle("ig_t5");
    step();
    idle("ig_t6");
    // drop to U, then reset in the middle of an ECALL
    issue(MRET, 64'h600, 64'h80);
    step();
    step();
    chk("rs_priv_u", {62'b0, bus.priv}, 64'd0);
    issue(ECALL, 64'h2008, 64'h0);
    step();
    wr("rs_cause", 12'h342, 64'd8);
    rst = 1'b1;
    #1;
    chk("rs_we", {63'b0, bus.csr_we}, 64'd0);
    chk("rs_addr", {52'b0, bus.csr_addr}, 64'd0);
    chk("rs_wdata", bus.csr_wdata, 64'd0);
    chk("rs_priv", {62'b0, bus.priv}, 64'd3);
    chk("rs_hold", {63'b0, bus.hold}, 64'd0);
    chk("rs_rv", {63'b0, bus.redirect_valid}, 64'd0);
    step();
    rst = 1'b0;
    step();
    idle("rs_after");
    issue(ECALL, 64'h300, 64'h0);
    wr("rs2_epc", 12'h341, 64'h300);
    step();
    wr("rs2_cause", 12'h342, 64'd11);
    step();
    wr("rs2_stat", 12'h300, 64'h1800);
    step();
    redir("rs2_redir", 64'h8000_2000);
    step();
    idle("rs2_done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
